// File: rtl/sb_sh_scheduler_fsm.sv
// Store-byte / store-halfword scheduler for the memory stage: does a read-modify-write
// of the containing word and stalls the pipeline until the merged word has been written.
module sb_sh_scheduler_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_waitrequest,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic        addr_err
);

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] addr_q;
  logic [15:0] data_q;
  logic [31:0] rbuf;
  logic        is_half_q;
  logic        trigger;
  logic        misaligned;
  logic        accept;
  logic [31:0] merged;
  logic        unused_wdata_hi;

  assign trigger         = instr_valid && ((op == OP_SB) || (op == OP_SH));
  assign misaligned      = (op == OP_SH) && addr[0];
  assign accept          = (state == IDLE) && trigger && !misaligned;
  assign unused_wdata_hi = ^wdata_in[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only the low halfword of rt can ever be stored, so the upper half is not kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= 32'd0;
      data_q    <= 16'd0;
      rbuf      <= 32'd0;
      is_half_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= addr;
        data_q    <= wdata_in[15:0];
        is_half_q <= (op == OP_SH);
      end
      if ((state == READ) && !mem_waitrequest) begin
        rbuf <= mem_rdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = READ;
      READ:    if (!mem_waitrequest) next_state = WRITE;
      WRITE:   if (!mem_waitrequest) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lanes: byte lane 0 and halfword 0 sit in the low-order bits.
  always_comb begin
    merged = rbuf;
    if (is_half_q) begin
      if (addr_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    addr_err  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          addr_err = misaligned;
          stall    = !misaligned;
        end
      end
      READ: begin
        mem_read = 1'b1;
        stall    = 1'b1;
      end
      WRITE: begin
        mem_write = 1'b1;
        stall     = 1'b1;
      end
      default: done = 1'b1;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merged;

endmodule

// File: tb/tb_sb_sh_scheduler_fsm.sv
// Directed bench for sb_sh_scheduler_fsm: a per-cycle expected timeline derived from the
// store's wait states, checked every cycle, plus literal checks on the committed writes.
module tb_sb_sh_scheduler_fsm;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        done;
  logic        addr_err;

  int testsRun = 0;
  int testsFailed = 0;

  bit          checkEn = 1'b0;
  logic        expStall, expRead, expWrite, expDone, expErr, expZero;
  logic [31:0] expAddr, expWdata;

  int          readCommits = 0, writeCommits = 0, stallCycles = 0, doneCount = 0, errCount = 0;
  int          baseRead, baseWrite, baseStall, baseDone, baseErr;
  logic [31:0] lastRaddr = 32'd0, lastWaddr = 32'd0, lastWdata = 32'd0;

  always #5 clk = ~clk;

  sb_sh_scheduler_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .op              (op),
    .addr            (addr),
    .wdata_in        (wdata_in),
    .mem_rdata       (mem_rdata),
    .mem_waitrequest (mem_waitrequest),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .stall           (stall),
    .done            (done),
    .addr_err        (addr_err)
  );

  // Reference merge: replace the addressed lane of the old word, computed with masks.
  function automatic logic [31:0] modelMerge(input logic [31:0] word, input logic [31:0] a,
                                             input logic [31:0] d, input bit half);
    int          sh;
    logic [31:0] mask;
    if (half) begin
      sh   = 16 * int'(a[1]);
      mask = 32'h0000FFFF << sh;
    end else begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'h000000FF << sh;
    end
    return (word & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareBit(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    compareBit("stall", stall, expStall);
    compareBit("mem_read", mem_read, expRead);
    compareBit("mem_write", mem_write, expWrite);
    compareBit("done", done, expDone);
    compareBit("addr_err", addr_err, expErr);
    compareBit("rd_wr_exclusive", mem_read & mem_write, 1'b0);
    if (expRead || expWrite) compare("mem_addr", mem_addr, expAddr);
    if (expWrite) compare("mem_wdata", mem_wdata, expWdata);
    if (expZero) begin
      compare("mem_addr_zero", mem_addr, 32'd0);
      compare("mem_wdata_zero", mem_wdata, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput();
      if (mem_read && !mem_waitrequest) begin
        readCommits++;
        lastRaddr = mem_addr;
      end
      if (mem_write && !mem_waitrequest) begin
        writeCommits++;
        lastWaddr = mem_addr;
        lastWdata = mem_wdata;
      end
      if (stall)    stallCycles++;
      if (done)     doneCount++;
      if (addr_err) errCount++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic setExp(input logic s, input logic r, input logic w, input logic d,
                        input logic e, input logic z, input logic [31:0] a, input logic [31:0] wd);
    expStall = s; expRead = r; expWrite = w; expDone = d; expErr = e; expZero = z;
    expAddr = a; expWdata = wd;
  endtask

  task automatic snap();
    baseRead = readCommits; baseWrite = writeCommits; baseStall = stallCycles;
    baseDone = doneCount;   baseErr = errCount;
  endtask

  task automatic checkDeltas(input string tag, input int rd, input int wr, input int st,
                             input int dn, input int er);
    compare({tag, "_reads"},  readCommits - baseRead,  rd);
    compare({tag, "_writes"}, writeCommits - baseWrite, wr);
    compare({tag, "_stalls"}, stallCycles - baseStall, st);
    compare({tag, "_dones"},  doneCount - baseDone,    dn);
    compare({tag, "_errs"},   errCount - baseErr,      er);
  endtask

  // One memory-stage instruction, held while stalled, with the given memory wait states.
  task automatic applyStimulus(input logic valid, input logic [5:0] o, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] memWord,
                               input int rWait, input int wWait);
    bit          isStore, half, bad;
    logic [31:0] wordAddr, merged;
    isStore  = valid && ((o == OP_SB) || (o == OP_SH));
    half     = (o == OP_SH);
    bad      = half && a[0];
    wordAddr = {a[31:2], 2'b00};
    merged   = modelMerge(memWord, a, wd, half);
    step();
    instr_valid = valid; op = o; addr = a; wdata_in = wd;
    mem_waitrequest = 1'b0; mem_rdata = JUNK;
    if (!isStore || bad) begin
      setExp(1'b0, 1'b0, 1'b0, 1'b0, isStore && bad, 1'b0, 32'd0, 32'd0);
      settle();
      return;
    end
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i <= rWait; i++) begin
      step();
      mem_waitrequest = (i < rWait);
      mem_rdata = (i < rWait) ? JUNK : memWord;
      setExp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wordAddr, 32'd0);
    end
    for (int i = 0; i <= wWait; i++) begin
      step();
      mem_waitrequest = (i < wWait);
      mem_rdata = JUNK;
      setExp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, wordAddr, merged);
    end
    step();
    mem_waitrequest = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
  endtask

  task automatic applyResetInWrite(input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] memWord);
    step();
    instr_valid = 1'b1; op = OP_SB; addr = a; wdata_in = wd;
    mem_waitrequest = 1'b0; mem_rdata = JUNK;
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    mem_rdata = memWord;
    setExp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {a[31:2], 2'b00}, 32'd0);
    step();
    mem_waitrequest = 1'b1; mem_rdata = JUNK; reset = 1'b1;
    setExp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {a[31:2], 2'b00}, modelMerge(memWord, a, wd, 1'b0));
    step();
    reset = 1'b0; instr_valid = 1'b0; mem_waitrequest = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    settle();
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; op = 6'd0; addr = 32'd0; wdata_in = 32'd0;
    mem_rdata = 32'd0; mem_waitrequest = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    checkEn = 1'b1;
    step();
    reset = 1'b0;
    step();
    settle();

    snap();
    applyStimulus(1'b1, OP_SB, 32'h00001003, 32'h000000AB, 32'h11223344, 0, 0);
    checkDeltas("sb_basic", 1, 1, 3, 1, 0);
    compare("sb_basic_wdata", lastWdata, 32'hAB223344);
    compare("sb_basic_waddr", lastWaddr, 32'h00001000);
    compare("sb_basic_raddr", lastRaddr, 32'h00001000);

    snap();
    applyStimulus(1'b1, OP_SH, 32'h00002002, 32'hFFFF5A5A, 32'hDEADBEEF, 0, 0);
    checkDeltas("sh_basic", 1, 1, 3, 1, 0);
    compare("sh_basic_wdata", lastWdata, 32'h5A5ABEEF);
    compare("sh_basic_waddr", lastWaddr, 32'h00002000);

    snap();
    applyStimulus(1'b1, OP_SH, 32'h00002001, 32'h00001234, 32'h0, 0, 0);
    checkDeltas("sh_odd", 0, 0, 0, 0, 1);

    snap();
    applyStimulus(1'b1, OP_LW, 32'h00001003, 32'h000000AB, 32'h0, 0, 0);
    applyStimulus(1'b0, OP_SB, 32'h00001003, 32'h000000AB, 32'h0, 0, 0);
    checkDeltas("passthru", 0, 0, 0, 0, 0);

    snap();
    applyStimulus(1'b1, OP_SB, 32'h00003001, 32'h00000077, 32'hAABBCCDD, 2, 3);
    checkDeltas("waits", 1, 1, 8, 1, 0);
    compare("waits_wdata", lastWdata, 32'hAABB77DD);

    applyStimulus(1'b1, OP_SH, 32'h00004000, 32'h1234BEEF, 32'h01020304, 0, 1);
    compare("sh_low_wdata", lastWdata, 32'h0102BEEF);
    applyStimulus(1'b1, OP_SB, 32'h00006002, 32'h0000005C, 32'hFFFFFFFF, 1, 0);
    compare("sb_lane2_wdata", lastWdata, 32'hFF5CFFFF);
    applyStimulus(1'b1, OP_SB, 32'h00007000, 32'h00000012, 32'h00000000, 0, 0);
    compare("sb_lane0_wdata", lastWdata, 32'h00000012);

    snap();
    applyResetInWrite(32'h00009002, 32'h00000034, 32'h10203040);
    checkDeltas("rst_write", 1, 0, 3, 0, 0);
    snap();
    applyStimulus(1'b1, OP_SB, 32'h00009002, 32'h00000034, 32'h10203040, 0, 0);
    checkDeltas("after_rst", 1, 1, 3, 1, 0);
    compare("after_rst_wdata", lastWdata, 32'h10343040);

    snap();
    applyStimulus(1'b1, OP_SB, 32'h00008000, 32'h00000001, 32'hA0A0A0A0, 0, 0);
    compare("b2b_first_wdata", lastWdata, 32'hA0A0A001);
    applyStimulus(1'b1, OP_SB, 32'h00008001, 32'h00000002, 32'hA0A0A001, 0, 0);
    compare("b2b_second_wdata", lastWdata, 32'hA0A00201);
    checkDeltas("b2b", 2, 2, 6, 2, 0);

    step();
    instr_valid = 1'b0;
    setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sb_sh_scheduler_fsm.md
SB_SH_SCHEDULER_FSM -- requirements
Module: sb_sh_scheduler_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset domain is permitted.
REQ-002 clk  input  1  rising-edge clock shared with the CPU core.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 instr_valid  input  1  op, addr and wdata_in hold a valid memory-stage instruction this cycle.
REQ-005 op  input  6  opcode of that instruction; SB = 6'b101000, SH = 6'b101001.
REQ-006 addr  input  32  byte address computed by the ALU (rs + sign-extended offset).
REQ-007 wdata_in  input  32  rt register value; the low byte or halfword is stored.
REQ-008 mem_rdata  input  32  word read data; valid in the cycle mem_read=1 and mem_waitrequest=0.
REQ-009 mem_waitrequest  input  1  memory not ready; holds the current request.
REQ-010 mem_addr  output  32  word-aligned address, equal to {addr_q[31:2],2'b00}.
REQ-011 mem_read  output  1  word read request.
REQ-012 mem_write  output  1  word write request.
REQ-013 mem_wdata  output  32  merged word to write.
REQ-014 stall  output  1  freezes PC and pipeline registers upstream of the memory stage.
REQ-015 done  output  1  one-cycle pulse: store committed.
REQ-016 addr_err  output  1  one-cycle pulse: SH to an odd address.

Function
REQ-017 States SHALL be IDLE, READ, WRITE, DONE, encoded as a registered 2-bit state.
REQ-018 Trigger = instr_valid and (op==SB or op==SH), evaluated only in IDLE.
REQ-019 IDLE, trigger, and (op==SB or addr[0]==0): latch addr_q, data_q, is_half_q; go to READ; stall=1 combinationally in this cycle.
REQ-020 IDLE, trigger, op==SH, addr[0]==1: assert addr_err for one cycle; no memory access; stay in IDLE; stall=0.
REQ-021 READ: mem_read=1 and mem_addr driven; hold while mem_waitrequest=1; when it is 0, latch mem_rdata into rbuf and go to WRITE.
REQ-022 Merge, little-endian lanes: SB replaces byte addr_q[1:0] (lane 0 = bits 7:0) with data_q[7:0]; SH replaces halfword addr_q[1] (0 = bits 15:0) with data_q[15:0]; all other bits come from rbuf.
REQ-023 WRITE: mem_write=1 and mem_wdata = merged word, both stable while mem_waitrequest=1; when it is 0, go to DONE.
REQ-024 DONE: done=1, stall=0, go to IDLE; the trigger is ignored in DONE so the same instruction cannot restart.
REQ-025 stall SHALL be 1 in READ and WRITE, and in IDLE on an accepted trigger; otherwise 0.
REQ-026 Minimum latency with zero wait states: stall high for exactly 3 cycles (IDLE-accept, READ, WRITE); done in the 4th cycle.
REQ-027 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-028 Non-SB/SH opcodes SHALL pass with stall=0 and no memory requests.

Reset
REQ-029 When reset=1 at a clock edge: state becomes IDLE; addr_q, data_q, rbuf and is_half_q become 0.
REQ-030 While in IDLE after reset, outputs SHALL be mem_read=0, mem_write=0, done=0, addr_err=0, stall=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset in READ or WRITE SHALL abandon the operation; no write request is issued after the reset edge.

Verification
REQ-032 SB: addr=0x1003, wdata_in=0x000000AB, memory word 0x11223344, no waits -> one read of 0x1000, then a write of 0xAB223344; stall high 3 cycles; done pulses once.
REQ-033 SH: addr=0x2002, wdata_in=0xFFFF5A5A, memory word 0xDEADBEEF -> write of 0x5A5ABEEF to 0x2000.
REQ-034 SH at addr=0x2001 -> addr_err pulses once; mem_read and mem_write stay 0; stall stays 0.
REQ-035 mem_waitrequest held high for 2 cycles in READ and 3 cycles in WRITE -> mem_addr and mem_wdata stable throughout; stall high for 8 cycles in total; a single write.
REQ-036 reset asserted in the WRITE state -> next cycle IDLE with all outputs 0; no done pulse; a following SB then completes normally.
REQ-037 Back-to-back SB, SB, each held by stall -> two separate read/write pairs; no duplicate store during a DONE cycle.
